// File: rtl/mod_n_counter_pkg.sv
// Shared types and elaboration helpers for the modulo-N counter family.
package mod_n_counter_pkg;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  // Legal configuration: 2 <= modulus <= 2^width.
  function automatic logic modulus_ok(input int width, input longint modulus);
    logic ok_v;
    if ((width < 32'sd1) || (width > 32'sd62)) begin
      ok_v = 1'b0;
    end else begin
      ok_v = (modulus >= 64'sd2) && (modulus <= (64'sd1 << width));
    end
    return ok_v;
  endfunction

  function automatic int term_value(input int modulus, input dir_e dir);
    int term_v;
    case (dir)
      DIR_UP:   term_v = modulus - 32'sd1;
      DIR_DOWN: term_v = 32'sd0;
      default:  term_v = 32'sd0;
    endcase
    return term_v;
  endfunction

endpackage

// File: rtl/mod_n_next.sv
// Next-state logic for mod_n_counter: load clamp, wrap detect, up/down step.
// Down counting exists only when MOD_N_COUNTER_DOWN_EN is defined.
module mod_n_next
  import mod_n_counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic [WIDTH-1:0] count,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] next_count,
  output logic             next_wrap
);

  localparam logic [WIDTH-1:0] MAX_C   = WIDTH'(term_value(MODULUS, DIR_UP));
  localparam logic [WIDTH-1:0] ONE_C   = WIDTH'(32'd1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);

  logic [WIDTH-1:0] inc_count_s;
  logic             inc_wrap_s;
  logic [WIDTH-1:0] load_count_s;

`ifdef MOD_N_COUNTER_DOWN_EN
  localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};

  dir_e             dir_s;
  logic [WIDTH-1:0] dec_count_s;
  logic             dec_wrap_s;

  assign dir_s = dir_e'(up);

  // Decrement with wrap from 0 back to MODULUS-1.
  always_comb begin
    dec_count_s = count - ONE_C;
    dec_wrap_s  = 1'b0;
    if (count == ZERO_C) begin
      dec_count_s = MAX_C;
      dec_wrap_s  = 1'b1;
    end else begin
      dec_wrap_s  = 1'b0;
    end
  end
`else
  logic up_unused_s;
  assign up_unused_s = up;
`endif

  // Increment with wrap from MODULUS-1 to 0; covers the full-range natural overflow too.
  always_comb begin
    inc_count_s = count + ONE_C;
    inc_wrap_s  = 1'b0;
    if (count == MAX_C) begin
      inc_count_s = {WIDTH{1'b0}};
      inc_wrap_s  = 1'b1;
    end else begin
      inc_wrap_s  = 1'b0;
    end
  end

  // Out-of-range load values clamp to the top of the count range.
  always_comb begin
    load_count_s = MAX_C;
    if ({1'b0, load_val} < MOD_EXT) begin
      load_count_s = load_val;
    end else begin
      load_count_s = MAX_C;
    end
  end

  // Priority: load > en > hold.
  always_comb begin
    next_count = count;
    next_wrap  = 1'b0;
    if (load) begin
      next_count = load_count_s;
      next_wrap  = 1'b0;
    end else if (en) begin
`ifdef MOD_N_COUNTER_DOWN_EN
      if (dir_s == DIR_DOWN) begin
        next_count = dec_count_s;
        next_wrap  = dec_wrap_s;
      end else begin
        next_count = inc_count_s;
        next_wrap  = inc_wrap_s;
      end
`else
      next_count = inc_count_s;
      next_wrap  = inc_wrap_s;
`endif
    end else begin
      next_count = count;
      next_wrap  = 1'b0;
    end
  end

endmodule

// File: rtl/mod_n_counter.sv
// Parametrised modulo-N counter with enable, clamped parallel load, terminal count
// and registered wrap pulse. Define MOD_N_COUNTER_DOWN_EN to honour the up input.
module mod_n_counter
  import mod_n_counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap
);

  if (!modulus_ok(WIDTH, longint'(MODULUS))) begin : g_bad_modulus
    $error("mod_n_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
  end

  localparam logic [WIDTH-1:0] TERM_UP = WIDTH'(term_value(MODULUS, DIR_UP));

  logic [WIDTH-1:0] count_r;
  logic             wrap_r;
  logic [WIDTH-1:0] next_count_s;
  logic             next_wrap_s;
  logic [WIDTH-1:0] term_s;

  mod_n_next #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_next (
    .count      (count_r),
    .en         (en),
    .up         (up),
    .load       (load),
    .load_val   (load_val),
    .next_count (next_count_s),
    .next_wrap  (next_wrap_s)
  );

  // Count and wrap state; reset clears both immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= {WIDTH{1'b0}};
      wrap_r  <= 1'b0;
    end else begin
      count_r <= next_count_s;
      wrap_r  <= next_wrap_s;
    end
  end

`ifdef MOD_N_COUNTER_DOWN_EN
  localparam logic [WIDTH-1:0] TERM_DOWN = WIDTH'(term_value(MODULUS, DIR_DOWN));

  // Terminal value follows the live direction input.
  always_comb begin
    term_s = TERM_UP;
    if (dir_e'(up) == DIR_UP) begin
      term_s = TERM_UP;
    end else begin
      term_s = TERM_DOWN;
    end
  end
`else
  assign term_s = TERM_UP;
`endif

  // tc stays combinational so a cascaded stage can use it as its enable on the same edge.
  assign tc    = en & (count_r == term_s);
  assign count = count_r;
  assign wrap  = wrap_r;

endmodule

// File: tb/tb_mod_n_counter.sv
// Scoreboard bench for mod_n_counter (10-state and 8-state instances).
module tb_mod_n_counter;

`ifdef MOD_N_COUNTER_DOWN_EN
  localparam bit DOWN_EN = 1'b1;
`else
  localparam bit DOWN_EN = 1'b0;
`endif
  localparam int M10 = 10;
  localparam int M8  = 8;

  typedef struct {
    int cnt;
    int wrp;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset, en, up, load;
  logic [3:0] load_val;
  logic [3:0] count;
  logic       tc, wrap;

  logic       reset8, en8, up8, load8;
  logic [2:0] load_val8;
  logic [2:0] count8;
  logic       tc8, wrap8;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   mc      = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  mod_n_counter #(.WIDTH(4), .MODULUS(M10)) dut (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
    .load_val(load_val), .count(count), .tc(tc), .wrap(wrap)
  );

  mod_n_counter #(.WIDTH(3), .MODULUS(M8)) dut8 (
    .clk(clk), .reset(reset8), .en(en8), .up(up8), .load(load8),
    .load_val(load_val8), .count(count8), .tc(tc8), .wrap(wrap8)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus on the 10-state counter, predict, then compare.
  task automatic step(input logic e, input logic u, input logic l, input logic [3:0] lv);
    int   term;
    bit   go_up;
    exp_t x;
    @(negedge clk);
    en = e; up = u; load = l; load_val = lv;
    go_up = DOWN_EN ? bit'(u) : 1'b1;
    term  = go_up ? M10 - 1 : 0;
    #1 check("tc", int'(tc), int'(e && (mc == term)));
    x.wrp = 0;
    if (l) begin
      mc = (int'(lv) < M10) ? int'(lv) : M10 - 1;
    end else if (e) begin
      if (go_up) begin
        x.wrp = (mc == M10 - 1) ? 1 : 0;
        mc = (mc + 1) % M10;
      end else begin
        x.wrp = (mc == 0) ? 1 : 0;
        mc = (mc + M10 - 1) % M10;
      end
    end
    x.cnt = mc;
    sb_q.push_back(x);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check("sb_empty", 1, 0);
    end else begin
      x = sb_q.pop_front();
      check("count", int'(count), x.cnt);
      check("wrap", int'(wrap), x.wrp);
    end
  endtask

  // Reset asserted between edges must clear outputs without a clock.
  task automatic mid_reset();
    @(posedge clk);
    #3 reset = 1'b1;
    #1 check("rst_count", int'(count), 0);
    check("rst_wrap", int'(wrap), 0);
    mc = 0;
    @(negedge clk);
    en = 1'b0; load = 1'b0;
    reset = 1'b0;
  endtask

  initial begin
    exp_t x;
    reset = 1'b1; en = 1'b1; up = 1'b0; load = 1'b0; load_val = 4'd0;
    reset8 = 1'b1; en8 = 1'b0; up8 = 1'b1; load8 = 1'b0; load_val8 = 3'd0;
    #12;
    check("reset_count", int'(count), 0);
    check("reset_wrap", int'(wrap), 0);
    check("reset_tc_down", int'(tc), DOWN_EN ? 1 : 0);
    up = 1'b1;
    #1 check("reset_tc_up", int'(tc), 0);
    @(negedge clk);
    reset = 1'b0; en = 1'b0;

    for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b0, 4'd0);

    step(1'b0, 1'b1, 1'b1, 4'd7);
    step(1'b1, 1'b1, 1'b0, 4'd0);
    step(1'b0, 1'b1, 1'b1, 4'd13);
    step(1'b1, 1'b1, 1'b1, 4'd3);
    step(1'b0, 1'b1, 1'b1, 4'd15);

    step(1'b0, 1'b1, 1'b1, 4'd1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 4'd0);

    step(1'b0, 1'b1, 1'b1, 4'd4);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 4'd0);

    for (int i = 0; i < 60; i++) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 5) == 0), 4'($urandom_range(0, 15)));
    end

    step(1'b0, 1'b1, 1'b1, 4'd6);
    mid_reset();
    step(1'b0, 1'b1, 1'b1, 4'd9);
    step(1'b1, 1'b1, 1'b0, 4'd0);
    mid_reset();
    step(1'b1, 1'b1, 1'b0, 4'd0);

    // Full-range instance: natural overflow must still pulse wrap.
    @(negedge clk);
    reset8 = 1'b0; en8 = 1'b1;
    for (int k = 0; k < 9; k++) begin
      #1 check("tc8", int'(tc8), (k % M8 == M8 - 1) ? 1 : 0);
      x.cnt = (k + 1) % M8;
      x.wrp = (k % M8 == M8 - 1) ? 1 : 0;
      sb_q.push_back(x);
      @(posedge clk);
      #1;
      x = sb_q.pop_front();
      check("count8", int'(count8), x.cnt);
      check("wrap8", int'(wrap8), x.wrp);
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
